// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU control decode, ALU/zero, EX/MEM pipeline register.
// Latency: one cycle from ID/EX inputs to *_ex_mem outputs.
// Backpressure: hold freezes EX/MEM (forwarding still sees held values); flush inserts a bubble and wins over hold.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        reg_dst,
    input  logic        reg_write,
    input  logic        alu_src,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        mem_to_reg,
    input  logic [1:0]  alu_op,
    input  logic [31:0] signextend,
    input  logic [5:0]  func,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [4:0]  rd,
    input  logic [4:0]  rt,
    input  logic [4:0]  rs,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        reg_write_ex_mem,
    output logic        mem_read_ex_mem,
    output logic        mem_write_ex_mem,
    output logic        mem_to_reg_ex_mem,
    output logic        branch_ex_mem,
    output logic        zero_ex_mem,
    output logic [31:0] alu_result_ex_mem,
    output logic [31:0] store_data_ex_mem,
    output logic [4:0]  dest_ex_mem
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOR  = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;
    localparam logic [2:0] ALU_NONE = 3'd7;

    logic        w_exm_hit_rs, w_exm_hit_rt, w_wb_hit_rs, w_wb_hit_rt;
    logic [31:0] w_fwd_rs, w_fwd_rt, w_op_b;
    logic [4:0]  w_dest;
    logic [2:0]  w_alu_ctrl;
    logic        w_illegal;
    logic [31:0] w_alu_result;
    logic        w_zero;

    // Index 0 is hardwired zero, so a match on it is never a real producer.
    assign w_exm_hit_rs = reg_write_ex_mem && (dest_ex_mem != 5'd0) && (dest_ex_mem == rs);
    assign w_exm_hit_rt = reg_write_ex_mem && (dest_ex_mem != 5'd0) && (dest_ex_mem == rt);
    assign w_wb_hit_rs  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs);
    assign w_wb_hit_rt  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rt);

    // EX/MEM is the younger producer, so it is checked before MEM/WB.
    assign w_fwd_rs = w_exm_hit_rs ? alu_result_ex_mem :
                      w_wb_hit_rs  ? wb_data : rs_data;
    assign w_fwd_rt = w_exm_hit_rt ? alu_result_ex_mem :
                      w_wb_hit_rt  ? wb_data : rt_data;

    assign w_op_b = alu_src ? signextend : w_fwd_rt;
    assign w_dest = reg_dst ? rd : rt;

    // ALU control decode; unknown R-type funct codes are flagged for bubbling.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_illegal  = 1'b0;
        case (alu_op)
            2'b00: w_alu_ctrl = ALU_ADD;
            2'b01: w_alu_ctrl = ALU_SUB;
            2'b11: w_alu_ctrl = ALU_SLT;
            default: begin
                case (func)
                    6'b100000: w_alu_ctrl = ALU_ADD;
                    6'b100010: w_alu_ctrl = ALU_SUB;
                    6'b100100: w_alu_ctrl = ALU_AND;
                    6'b100101: w_alu_ctrl = ALU_OR;
                    6'b100110: w_alu_ctrl = ALU_XOR;
                    6'b100111: w_alu_ctrl = ALU_NOR;
                    6'b101010: w_alu_ctrl = ALU_SLT;
                    default: begin
                        w_alu_ctrl = ALU_NONE;
                        w_illegal  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // ALU datapath; add/sub wrap, SLT is a signed compare.
    always_comb begin
        w_alu_result = 32'h0;
        case (w_alu_ctrl)
            ALU_ADD: w_alu_result = w_fwd_rs + w_op_b;
            ALU_SUB: w_alu_result = w_fwd_rs - w_op_b;
            ALU_AND: w_alu_result = w_fwd_rs & w_op_b;
            ALU_OR:  w_alu_result = w_fwd_rs | w_op_b;
            ALU_XOR: w_alu_result = w_fwd_rs ^ w_op_b;
            ALU_NOR: w_alu_result = ~(w_fwd_rs | w_op_b);
            ALU_SLT: w_alu_result = ($signed(w_fwd_rs) < $signed(w_op_b)) ? 32'h1 : 32'h0;
            default: w_alu_result = 32'h0;
        endcase
    end

    assign w_zero = (w_alu_result == 32'h0);

    // EX/MEM register: async clear, then flush over hold over capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_ex_mem  <= 1'b0;
            mem_read_ex_mem   <= 1'b0;
            mem_write_ex_mem  <= 1'b0;
            mem_to_reg_ex_mem <= 1'b0;
            branch_ex_mem     <= 1'b0;
            zero_ex_mem       <= 1'b0;
            alu_result_ex_mem <= 32'h0;
            store_data_ex_mem <= 32'h0;
            dest_ex_mem       <= 5'h0;
        end else if (flush) begin
            reg_write_ex_mem  <= 1'b0;
            mem_read_ex_mem   <= 1'b0;
            mem_write_ex_mem  <= 1'b0;
            mem_to_reg_ex_mem <= 1'b0;
            branch_ex_mem     <= 1'b0;
            zero_ex_mem       <= 1'b0;
            alu_result_ex_mem <= 32'h0;
            store_data_ex_mem <= 32'h0;
            dest_ex_mem       <= 5'h0;
        end else if (!hold) begin
            reg_write_ex_mem  <= reg_write & ~w_illegal;
            mem_read_ex_mem   <= mem_read  & ~w_illegal;
            mem_write_ex_mem  <= mem_write & ~w_illegal;
            mem_to_reg_ex_mem <= mem_to_reg;
            branch_ex_mem     <= branch;
            zero_ex_mem       <= w_zero;
            alu_result_ex_mem <= w_alu_result;
            store_data_ex_mem <= w_fwd_rt;
            dest_ex_mem       <= w_dest;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors push expected EX/MEM contents into a scoreboard.
// Latency: expectations are tagged with the edge count at which they must appear.
// Backpressure: hold/flush vectors carry their own expected (held or cleared) contents.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, hold;
    logic        reg_dst, reg_write, alu_src, mem_read, mem_write, branch, mem_to_reg;
    logic [1:0]  alu_op;
    logic [31:0] signextend;
    logic [5:0]  func;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  rd, rt, rs;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        reg_write_ex_mem, mem_read_ex_mem, mem_write_ex_mem;
    logic        mem_to_reg_ex_mem, branch_ex_mem, zero_ex_mem;
    logic [31:0] alu_result_ex_mem, store_data_ex_mem;
    logic [4:0]  dest_ex_mem;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        br;
        logic        z;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  dest;
    } out_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    q_cyc[$];
    out_t  q_exp[$];
    string q_nm[$];

    ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .signextend(signextend),
        .func(func), .rs_data(rs_data), .rt_data(rt_data),
        .rd(rd), .rt(rt), .rs(rs),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .reg_write_ex_mem(reg_write_ex_mem), .mem_read_ex_mem(mem_read_ex_mem),
        .mem_write_ex_mem(mem_write_ex_mem), .mem_to_reg_ex_mem(mem_to_reg_ex_mem),
        .branch_ex_mem(branch_ex_mem), .zero_ex_mem(zero_ex_mem),
        .alu_result_ex_mem(alu_result_ex_mem), .store_data_ex_mem(store_data_ex_mem),
        .dest_ex_mem(dest_ex_mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic out_t mk(input logic rw_, input logic mr_, input logic mw_,
                                input logic m2r_, input logic br_, input logic z_,
                                input logic [31:0] res_, input logic [31:0] sd_,
                                input logic [4:0] dest_);
        out_t o;
        o.rw = rw_; o.mr = mr_; o.mw = mw_; o.m2r = m2r_; o.br = br_; o.z = z_;
        o.res = res_; o.sd = sd_; o.dest = dest_;
        return o;
    endfunction

    function automatic out_t act();
        return mk(reg_write_ex_mem, mem_read_ex_mem, mem_write_ex_mem, mem_to_reg_ex_mem,
                  branch_ex_mem, zero_ex_mem, alu_result_ex_mem, store_data_ex_mem, dest_ex_mem);
    endfunction

    task automatic cmp(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got rw=%b mr=%b mw=%b m2r=%b br=%b z=%b res=%h sd=%h dest=%0d ; want rw=%b mr=%b mw=%b m2r=%b br=%b z=%b res=%h sd=%h dest=%0d",
                     nm, a.rw, a.mr, a.mw, a.m2r, a.br, a.z, a.res, a.sd, a.dest,
                     e.rw, e.mr, e.mw, e.m2r, e.br, e.z, e.res, e.sd, e.dest);
        end
    endtask

    // Monitor: compare every expectation due at this edge.
    always @(posedge clk) begin
        #1;
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            cmp(q_nm[0], act(), q_exp[0]);
            void'(q_cyc.pop_front());
            void'(q_exp.pop_front());
            void'(q_nm.pop_front());
        end
    end

    task automatic idle();
        flush = 0; hold = 0;
        reg_dst = 0; reg_write = 0; alu_src = 0; mem_read = 0; mem_write = 0;
        branch = 0; mem_to_reg = 0; alu_op = 2'b00; signextend = 32'h0; func = 6'h0;
        rs_data = 32'h0; rt_data = 32'h0; rd = 0; rt = 0; rs = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 32'h0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [4:0] s, input logic [31:0] sdat,
                         input logic [4:0] t, input logic [31:0] tdat, input logic [4:0] d);
        idle();
        alu_op = 2'b10; func = f; reg_dst = 1; reg_write = 1;
        rs = s; rs_data = sdat; rt = t; rt_data = tdat; rd = d;
    endtask

    // Inputs are already driven; expectation belongs to the next edge.
    task automatic issue(input string nm, input out_t e);
        q_cyc.push_back(cyc + 1);
        q_exp.push_back(e);
        q_nm.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        idle();
        rst = 0;
        // Reset held with random inputs: outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            {reg_dst, reg_write, alu_src, mem_read, mem_write, branch, mem_to_reg} = 7'($urandom);
            alu_op = 2'($urandom); func = 6'($urandom); flush = 1'($urandom); hold = 1'($urandom);
            rs_data = $urandom; rt_data = $urandom; signextend = $urandom;
            rd = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
            wb_reg_write = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
            @(negedge clk);
            cmp("reset_hold", act(), '0);
        end
        idle();
        rst = 1;

        rtype(6'b100000, 1, 32'd5, 2, 32'd7, 3);
        issue("add_r3", mk(1,0,0,0,0,0, 32'd12, 32'd7, 3));
        // EX/MEM forward: r3=12, stale rs_data=0 -> 12-5.
        rtype(6'b100010, 3, 32'd0, 1, 32'd5, 4);
        issue("fwd_exmem", mk(1,0,0,0,0,0, 32'd7, 32'd5, 4));
        // Only MEM/WB matches r3: 20-5.
        rtype(6'b100010, 3, 32'd0, 1, 32'd5, 4);
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'd20;
        issue("fwd_memwb", mk(1,0,0,0,0,0, 32'd15, 32'd5, 4));
        // Both match r4: EX/MEM holds 15, MEM/WB offers 100 -> 15-5.
        rtype(6'b100010, 4, 32'd0, 1, 32'd5, 5);
        wb_reg_write = 1; wb_rd = 4; wb_data = 32'd100;
        issue("fwd_both", mk(1,0,0,0,0,0, 32'd10, 32'd5, 5));
        // r0 never forwarded.
        rtype(6'b100000, 0, 32'd0, 2, 32'd7, 6);
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'd99;
        issue("reg_zero", mk(1,0,0,0,0,0, 32'd7, 32'd7, 6));
        // Ensure EX/MEM dest 0 with write enable is also ignored.
        rtype(6'b100000, 0, 32'd4, 0, 32'd1, 0);
        issue("write_r0", mk(1,0,0,0,0,0, 32'd5, 32'd1, 0));
        rtype(6'b100000, 0, 32'd2, 0, 32'd3, 7);
        issue("no_fwd_r0", mk(1,0,0,0,0,0, 32'd5, 32'd3, 7));
        rtype(6'b101010, 7, 32'hFFFF_FFFF, 8, 32'd1, 9);
        rs = 10;
        issue("slt_neg", mk(1,0,0,0,0,0, 32'd1, 32'd1, 9));
        rtype(6'b101010, 10, 32'd1, 11, 32'hFFFF_FFFF, 9);
        issue("slt_false", mk(1,0,0,0,0,1, 32'd0, 32'hFFFF_FFFF, 9));
        // slti: 3 < 5, dest = rt.
        idle(); alu_op = 2'b11; alu_src = 1; reg_write = 1; signextend = 32'd5;
        rs = 12; rs_data = 32'd3; rt = 8; rt_data = 32'd1;
        issue("slti", mk(1,0,0,0,0,0, 32'd1, 32'd1, 8));
        // sw: 16 + (-4), store data from MEM/WB.
        idle(); alu_op = 2'b00; alu_src = 1; mem_write = 1; signextend = 32'hFFFF_FFFC;
        rs = 10; rs_data = 32'd16; rt = 11; rt_data = 32'd0;
        wb_reg_write = 1; wb_rd = 11; wb_data = 32'h0000_ABCD;
        issue("sw", mk(0,0,1,0,0,0, 32'd12, 32'h0000_ABCD, 11));
        idle(); alu_op = 2'b00; alu_src = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1;
        signextend = 32'd8; rs = 10; rs_data = 32'd16; rt = 12; rt_data = 32'h55;
        issue("lw", mk(1,1,0,1,0,0, 32'd24, 32'h55, 12));
        rtype(6'b100100, 13, 32'hF0F0_00FF, 14, 32'h0FF0_0F0F, 15);
        issue("and", mk(1,0,0,0,0,0, 32'h00F0_000F, 32'h0FF0_0F0F, 15));
        rtype(6'b100101, 13, 32'hF0F0_00FF, 14, 32'h0FF0_0F0F, 15);
        issue("or", mk(1,0,0,0,0,0, 32'hFFF0_0FFF, 32'h0FF0_0F0F, 15));
        rtype(6'b100110, 13, 32'hF0F0_00FF, 14, 32'h0FF0_0F0F, 15);
        issue("xor", mk(1,0,0,0,0,0, 32'hFF00_0FF0, 32'h0FF0_0F0F, 15));
        rtype(6'b100111, 13, 32'hF0F0_00FF, 14, 32'h0FF0_0F0F, 15);
        issue("nor", mk(1,0,0,0,0,0, 32'h000F_F000, 32'h0FF0_0F0F, 15));
        // Hold: new inputs ignored, previous contents retained.
        rtype(6'b100000, 1, 32'd1, 2, 32'd1, 16);
        hold = 1;
        issue("hold", mk(1,0,0,0,0,0, 32'h000F_F000, 32'h0FF0_0F0F, 15));
        rtype(6'b100000, 1, 32'd1, 2, 32'd1, 16);
        flush = 1; hold = 1;
        issue("flush_hold", '0);
        idle(); alu_op = 2'b01; branch = 1; rs = 1; rs_data = 32'd9; rt = 2; rt_data = 32'd9;
        issue("beq_eq", mk(0,0,0,0,1,1, 32'd0, 32'd9, 2));
        rtype(6'b111111, 22, 32'd3, 21, 32'd4, 20);
        mem_write = 1;
        issue("illegal_func", mk(0,0,0,0,0,1, 32'd0, 32'd4, 20));
        rtype(6'b100000, 1, 32'd5, 2, 32'd7, 3);
        issue("add_again", mk(1,0,0,0,0,0, 32'd12, 32'd7, 3));

        // Async reset pulse mid-cycle, away from any edge.
        @(posedge clk); #3;
        rst = 0;
        #1;
        cmp("async_reset", act(), '0);
        #1;
        rst = 1;
        @(negedge clk);
        rtype(6'b100000, 1, 32'd5, 2, 32'd7, 3);
        issue("post_reset_add", mk(1,0,0,0,0,0, 32'd12, 32'd7, 3));
        idle();

        for (int i = 0; i < 5 && q_cyc.size() > 0; i++) @(negedge clk);
        if (q_cyc.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_cyc.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline, directly downstream of the ID/EX register. It takes the ID/EX register outputs, resolves RAW hazards by forwarding from its own EX/MEM outputs and from the MEM/WB writeback value, and decodes ALU control. It computes the ALU result and zero flag and registers everything the MEM stage needs into the EX/MEM pipeline register, with synchronous flush and hold.

## Interface
- No parameters; data width is fixed at 32 bits and register index width at 5 bits.
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset; all registered outputs are cleared while low.
- flush  in  1  synchronous; the next edge loads a bubble, with all outputs at their reset values.
- hold  in  1  synchronous; the next edge keeps the EX/MEM contents unchanged.
- reg_dst, reg_write, alu_src, mem_read, mem_write, branch, mem_to_reg  in  1 each  control bits from ID/EX.
- alu_op  in  2  ALU operation class from ID/EX.
- signextend  in  32  immediate from ID/EX.
- func  in  6  R-type function field from ID/EX.
- rs_data, rt_data  in  32 each  register-file read data from ID/EX.
- rd, rt, rs  in  5 each  register indices from ID/EX.
- wb_reg_write  in  1  MEM/WB write enable, used for forwarding.
- wb_rd  in  5  MEM/WB destination index.
- wb_data  in  32  MEM/WB final writeback value.
- reg_write_ex_mem, mem_read_ex_mem, mem_write_ex_mem, mem_to_reg_ex_mem, branch_ex_mem  out  1 each  registered control bits.
- zero_ex_mem  out  1  registered; high when the ALU result == 0.
- alu_result_ex_mem  out  32  registered ALU result.
- store_data_ex_mem  out  32  registered forwarded rt value.
- dest_ex_mem  out  5  registered destination index.

## Operation
- **Forward A (rs).** Selected by priority:
  - alu_result_ex_mem, if reg_write_ex_mem && dest_ex_mem != 0 && dest_ex_mem == rs;
  - else wb_data, if wb_reg_write && wb_rd != 0 && wb_rd == rs;
  - else rs_data.
- **Forward B (rt).** Same rule using rt; the result is fwd_rt.
- **ALU operands.**
  - Operand A = fwd_rs.
  - Operand B = alu_src ? signextend : fwd_rt.
  - Store data is always fwd_rt, never the immediate.
- **Destination.** dest = reg_dst ? rd : rt.
- **ALU control.**
  - alu_op 00 → ADD (lw/sw address).
  - alu_op 01 → SUB (beq compare).
  - alu_op 11 → SLT (slti).
  - alu_op 10 → decode func:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
    - Any other func → result 32'h0, and the bubble rule below applies.
- **Arithmetic.** ADD and SUB wrap modulo 2^32; no overflow trap. SLT is a signed two's-complement compare and yields 32'h1 or 32'h0.
- **Zero flag.** zero = (ALU result == 32'h0), computed before registering.
- **Bubble rule.** An R-type instruction with an unsupported func is registered with reg_write, mem_read and mem_write forced to 0. All other fields pass through unchanged.
- **EX/MEM register update at each rising edge.** Priority, highest first:
  - rst low → clear all outputs (asynchronous);
  - flush → clear all outputs;
  - hold → keep all outputs;
  - otherwise → capture the new values.
- **Flush vs hold.** flush dominates hold when both are high.
- **Reset values.** Every output is 0: all 1-bit outputs 0, alu_result_ex_mem and store_data_ex_mem 32'h0, dest_ex_mem 5'h0.

## Timing
- Forwarding, ALU control, ALU and zero are purely combinational from the ID/EX inputs and the current EX/MEM outputs.
- Latency is one cycle: inputs present before edge N appear on the *_ex_mem outputs after edge N.
- Back-to-back dependent instructions need no stall. The instruction in EX sees its predecessor's result through alu_result_ex_mem in the same cycle.
- A load followed by a dependent use is not resolved here; the upstream hazard unit must insert a bubble. During hold, forwarding still uses the held EX/MEM values.
- If EX/MEM and MEM/WB both match, EX/MEM wins (it is the younger result).
- Register index 0 is never forwarded, even with its write enable high.
- rst deasserting between edges: the first capture happens at the next rising edge.
- rst asserting mid-cycle: outputs clear immediately, without waiting for an edge.

## Test plan
- **Reset:** hold rst low, drive random inputs → all outputs stay 0. Release rst, apply ADD rs=1 (5), rt=2 (7), rd=3 → after 1 edge: alu_result_ex_mem=12, dest_ex_mem=3, reg_write_ex_mem=1, zero_ex_mem=0.
- **Forwarding chain:**
  - ADD r3=r1+r2 (5+7), then SUB r4=r3-r1 with stale rs_data=0 → result 7, taken from the EX/MEM forward.
  - Repeat with only the MEM/WB match (wb_rd=3, wb_data=20) → result 15.
  - Repeat with both matching → the EX/MEM value is used.
- **Register zero and SLT:** wb_rd=0 with wb_reg_write=1 and wb_data=99, rs=0 with rs_data=0 → operand stays 0. SLT with -1 vs 1 → alu_result_ex_mem=1.
- **sw path:** alu_op=00, alu_src=1, signextend=32'hFFFF_FFFC, rs_data=16, rt forwarded from MEM/WB (wb_data=32'hABCD) → alu_result_ex_mem=12, store_data_ex_mem=32'hABCD, mem_write_ex_mem=1.
- **flush / hold:**
  - hold one cycle → outputs unchanged.
  - flush and hold together → all outputs 0.
  - beq with equal operands → zero_ex_mem=1, branch_ex_mem=1.
- **Illegal func and async reset:** func=6'b111111 with reg_write=1 → reg_write_ex_mem=0 and alu_result_ex_mem=0. Pulse rst low mid-cycle → outputs clear before the next edge.
